credit_link_sender: RTL and testbench

CREDIT_LINK_SENDER -- requirements
Module: credit_link_sender

---
 rtl/credit_link_sender.sv | 75 +++++++
 tb/tb_credit_link_sender.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/credit_link_sender.sv
// Credit-based link sender: a 2-entry holding FIFO feeds a registered TX stage.
// A flit is sent only while downstream credits remain.
module credit_link_sender #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CREDIT_INIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  valid_out,
  input  logic                  credit_in,
  output logic [2:0]            credit_count,
  output logic                  credit_error
);

  localparam logic [2:0] CINIT = 3'(CREDIT_INIT);

  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  push;
  logic                  send;

  assign ready_out = reset && (occ < 2'd2);
  assign push      = valid_in && ready_out;
  assign send      = (occ != 2'd0) && (credit_count != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
      TX           <= '0;
      valid_out    <= 1'b0;
      credit_count <= CINIT;
      credit_error <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= data_in;
        wr_ptr       <= ~wr_ptr;
      end

      if (send) begin
        TX        <= fifo[rd_ptr];
        rd_ptr    <= ~rd_ptr;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end

      case ({push, send})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      // A credit returned while already full signals a downstream protocol
      // fault: saturate the count and latch the error.
      if (send && !credit_in) begin
        credit_count <= credit_count - 3'd1;
      end else if (credit_in && !send) begin
        if (credit_count == CINIT) begin
          credit_error <= 1'b1;
        end else begin
          credit_count <= credit_count + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_credit_link_sender.sv
// Directed bench for credit_link_sender; expected values worked out by hand
// from the edge-by-edge behaviour of the buffer and credit counter.
module tb_credit_link_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] TX;
  logic        valid_out;
  logic        credit_in;
  logic [2:0]  credit_count;
  logic        credit_error;

  int tests = 0;
  int fails = 0;

  logic [31:0] flits [5];

  credit_link_sender #(.DATA_WIDTH(32), .CREDIT_INIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .TX           (TX),
    .valid_out    (valid_out),
    .credit_in    (credit_in),
    .credit_count (credit_count),
    .credit_error (credit_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    flits[0] = 32'hA000_000A;
    flits[1] = 32'hB000_000B;
    flits[2] = 32'hC000_000C;
    flits[3] = 32'hD000_000D;
    flits[4] = 32'hE000_000E;

    reset = 1'b0; valid_in = 1'b0; credit_in = 1'b0; data_in = '0;
    step();
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_tx", TX, 32'd0);
    chk("rst_credit", 32'(credit_count), 32'd4);
    chk("rst_err", 32'(credit_error), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(ready_out), 32'd1);

    // A..E back to back, no credits returned: A..D go out, E stays buffered
    for (int i = 0; i < 5; i++) begin
      data_in = flits[i]; valid_in = 1'b1;
      chk("ab_ready", 32'(ready_out), 32'd1);
      step();
      if (i == 0) begin
        chk("ab_nobypass", 32'(valid_out), 32'd0);
      end else begin
        chk("ab_valid", 32'(valid_out), 32'd1);
        chk("ab_tx", TX, flits[i-1]);
        chk("ab_credit", 32'(credit_count), 32'(4 - i));
      end
    end
    valid_in = 1'b0;
    step();
    chk("e_held_valid", 32'(valid_out), 32'd0);
    chk("e_held_tx", TX, flits[3]);
    chk("e_held_credit", 32'(credit_count), 32'd0);

    // one credit: usable only from the following edge
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    chk("cr_nosend", 32'(valid_out), 32'd0);
    chk("cr_count1", 32'(credit_count), 32'd1);
    step();
    chk("e_valid", 32'(valid_out), 32'd1);
    chk("e_tx", TX, flits[4]);
    chk("e_credit", 32'(credit_count), 32'd0);
    step();
    chk("e_after", 32'(valid_out), 32'd0);

    // no credits: F,G fill the buffer, H is refused until space opens
    valid_in = 1'b1; data_in = 32'h0000_00F0;
    step();
    data_in = 32'h0000_00F1;
    step();
    chk("fg_full", 32'(ready_out), 32'd0);
    data_in = 32'h0000_00F2;
    step();
    chk("h_refused_ready", 32'(ready_out), 32'd0);
    chk("h_refused_valid", 32'(valid_out), 32'd0);
    credit_in = 1'b1;
    step();
    chk("fgh_c1_nosend", 32'(valid_out), 32'd0);
    chk("fgh_c1_count", 32'(credit_count), 32'd1);
    step();
    chk("f_valid", 32'(valid_out), 32'd1);
    chk("f_tx", TX, 32'h0000_00F0);
    chk("f_credit", 32'(credit_count), 32'd1);
    chk("f_ready", 32'(ready_out), 32'd1);
    step();
    credit_in = 1'b0; valid_in = 1'b0;
    chk("g_valid", 32'(valid_out), 32'd1);
    chk("g_tx", TX, 32'h0000_00F1);
    step();
    chk("h_valid", 32'(valid_out), 32'd1);
    chk("h_tx", TX, 32'h0000_00F2);
    chk("h_credit", 32'(credit_count), 32'd0);
    step();
    chk("h_after", 32'(valid_out), 32'd0);

    // credit_count 2, send coinciding with credit_in keeps the count
    credit_in = 1'b1;
    step();
    step();
    credit_in = 1'b0;
    chk("two_credit", 32'(credit_count), 32'd2);
    valid_in = 1'b1; data_in = 32'h1234_5678;
    step();
    valid_in = 1'b0; credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    chk("coin_valid", 32'(valid_out), 32'd1);
    chk("coin_tx", TX, 32'h1234_5678);
    chk("coin_credit", 32'(credit_count), 32'd2);

    // overflow: credit at the full count saturates and sets a sticky error
    credit_in = 1'b1;
    step();
    step();
    chk("full_credit", 32'(credit_count), 32'd4);
    chk("full_noerr", 32'(credit_error), 32'd0);
    step();
    credit_in = 1'b0;
    chk("ovf_credit", 32'(credit_count), 32'd4);
    chk("ovf_err", 32'(credit_error), 32'd1);
    step();
    step();
    chk("ovf_sticky", 32'(credit_error), 32'd1);

    // drain credits to 0 with five flits, buffer a sixth, then one credit
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; data_in = 32'h5000_0000 + 32'(i);
      step();
    end
    valid_in = 1'b0;
    chk("pre_rst_tx", TX, 32'h5000_0003);
    chk("pre_rst_full", 32'(ready_out), 32'd0);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    chk("pre_rst_credit", 32'(credit_count), 32'd1);

    // reset mid-operation overrides push and credit_in on the same edge
    reset = 1'b0; valid_in = 1'b1; credit_in = 1'b1; data_in = 32'hDEAD_BEEF;
    #1;
    chk("in_rst_ready", 32'(ready_out), 32'd0);
    step();
    chk("mrst_valid", 32'(valid_out), 32'd0);
    chk("mrst_tx", TX, 32'd0);
    chk("mrst_credit", 32'(credit_count), 32'd4);
    chk("mrst_err", 32'(credit_error), 32'd0);
    reset = 1'b1; valid_in = 1'b0; credit_in = 1'b0;
    #1;
    chk("mrst_rel_ready", 32'(ready_out), 32'd1);
    step();
    chk("mrst_stale1", 32'(valid_out), 32'd0);
    chk("mrst_tx1", TX, 32'd0);
    chk("mrst_ready1", 32'(ready_out), 32'd1);
    chk("mrst_credit1", 32'(credit_count), 32'd4);
    step();
    chk("mrst_stale2", 32'(valid_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
